// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester (fetch/load-store) arbiter for one single-ported memory
// Define ARB_DATA_PRIORITY_EN to give D fixed priority on ties instead of round-robin.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic          mem_sel,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

  state_t     state, state_nxt;
  logic       owner, owner_nxt;   // 0 = I, 1 = D
  logic [3:0] lat_cnt, lat_cnt_nxt;
  logic       winner;
  logic       capture;

`ifdef ARB_DATA_PRIORITY_EN
  assign winner = d_req;
`else
  logic last_grant;

  // On a tie, the requester that was not granted last time wins.
  assign winner = (i_req & d_req) ? ~last_grant : d_req;

  always_ff @(posedge clk) begin
    if (rst)
      last_grant <= 1'b1;
    else if (state == IDLE && (i_req | d_req))
      last_grant <= winner;
  end
`endif

  assign capture = (state == WAIT) && (lat_cnt == LAT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= 1'b0;
      lat_cnt <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      state   <= state_nxt;
      owner   <= owner_nxt;
      lat_cnt <= lat_cnt_nxt;
      if (capture) begin
        if (owner)
          d_rdata <= mem_rdata;
        else
          i_rdata <= mem_rdata;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    lat_cnt_nxt = lat_cnt;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_sel     = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    i_gnt       = 1'b0;
    d_gnt       = 1'b0;
    i_rvalid    = 1'b0;
    d_rvalid    = 1'b0;
    case (state)
      IDLE: begin
        if (i_req | d_req) begin
          owner_nxt = winner;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        mem_en    = 1'b1;
        mem_sel   = owner;
        mem_addr  = owner ? d_addr : i_addr;
        mem_we    = owner & d_we;
        mem_wdata = owner ? d_wdata : '0;
        i_gnt     = ~owner;
        d_gnt     = owner;
        if (owner && d_we) begin
          state_nxt = IDLE;
        end else begin
          lat_cnt_nxt = '0;
          state_nxt   = WAIT;
        end
      end
      WAIT: begin
        mem_sel     = owner;
        lat_cnt_nxt = lat_cnt + 4'd1;
        if (capture)
          state_nxt = RESP;
      end
      RESP: begin
        mem_sel   = owner;
        i_rvalid  = ~owner;
        d_rvalid  = owner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_gnt, i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_en, mem_we, mem_sel;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = 32'hBADBAD00;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic d; logic [31:0] data;} rsp_t;
  typedef struct {
    logic        d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  rsp_t        rq[$];
  logic        gq[$];
  logic [31:0] last_i = '0;
  logic [31:0] last_d = '0;
  int          mcnt = 0;
  logic [31:0] mpend = '0;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    case (a)
      32'h40:  return 32'h0000_0013;
      32'h200: return 32'hCAFE_F00D;
      default: return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Memory model: read data appears only in the cycle MEM_LAT after mem_en, garbage otherwise.
  always @(negedge clk) begin
    if (mcnt > 0) begin
      mcnt = mcnt - 1;
      mem_rdata = (mcnt == 0) ? mpend : 32'hBADBAD00;
    end else begin
      mem_rdata = 32'hBADBAD00;
    end
    if (mem_en && !mem_we) begin
      mpend = mem_val(mem_addr);
      mcnt  = LAT;
    end
  end

  // Scoreboard: grants and responses are popped in order as the DUT produces them.
  always @(negedge clk) begin : mon
    rsp_t r;
    logic e;
    if (i_gnt || d_gnt) begin
      if (gq.size() == 0) begin
        chk("unexpected_gnt", {i_gnt, d_gnt}, 0);
      end else begin
        e = gq.pop_front();
        chk("gnt_owner", {i_gnt, d_gnt}, e ? 2'b01 : 2'b10);
      end
    end
    if (i_rvalid || d_rvalid) begin
      if (rq.size() == 0) begin
        chk("unexpected_rvalid", {i_rvalid, d_rvalid}, 0);
      end else begin
        r = rq.pop_front();
        chk("rvalid_port", {i_rvalid, d_rvalid}, r.d ? 2'b01 : 2'b10);
        chk("rdata", r.d ? d_rdata : i_rdata, r.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sig(input logic d, input logic gnt, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(gnt ? (d ? d_gnt : i_gnt) : (d ? d_rvalid : i_rvalid)) && cyc < 40);
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
             mem_en, mem_we, mem_sel, mem_addr, mem_wdata}, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_req = 1'b0;
    d_req = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    gq.delete();
    rq.delete();
    last_i = '0;
    last_d = '0;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int   c;
    rsp_t r;
    gq.push_back(v.d);
    if (!v.we) begin
      r.d = v.d;
      r.data = v.exp_rdata;
      rq.push_back(r);
    end
    i_req   = ~v.d;
    d_req   = v.d;
    d_we    = v.we;
    i_addr  = v.d ? ~v.addr : v.addr;
    d_addr  = v.d ? v.addr : ~v.addr;
    d_wdata = v.wdata;
    wait_sig(v.d, 1'b1, c);
    chk({nm, "_gnt_seen"}, c < 40, 1);
    chk({nm, "_issue"}, {mem_en, mem_we, mem_sel, mem_addr, mem_wdata},
        {1'b1, v.exp_we, v.d, v.addr, v.exp_wdata});
    tick();
    i_req = 1'b0;
    d_req = 1'b0;
    if (v.we) begin
      @(negedge clk);
      chk({nm, "_wr_idle"}, {mem_en, mem_sel}, 0);
      repeat (LAT + 2) tick();
    end else begin
      wait_sig(v.d, 1'b0, c);
      chk({nm, "_latency"}, c, LAT + 1);
      chk({nm, "_other_rdata"}, v.d ? i_rdata : d_rdata, v.d ? last_i : last_d);
      if (v.d) last_d = v.exp_rdata;
      else     last_i = v.exp_rdata;
      @(negedge clk);
      chk({nm, "_rd_idle"}, {mem_en, mem_sel}, 0);
      tick();
    end
  endtask

  initial begin : main
    vec_t vecs[6];
    vec_t v;
    int   c, ng, ri, dg, cnt;
    rsp_t r;
    logic e;

    vecs[0] = '{d:1'b0, we:1'b0, addr:32'h40,  wdata:32'hFFFF_FFFF, exp_we:1'b0, exp_wdata:32'h0,         exp_rdata:32'h0000_0013};
    vecs[1] = '{d:1'b1, we:1'b1, addr:32'h100, wdata:32'hDEAD_BEEF, exp_we:1'b1, exp_wdata:32'hDEAD_BEEF, exp_rdata:32'h0};
    vecs[2] = '{d:1'b1, we:1'b0, addr:32'h200, wdata:32'h1111_1111, exp_we:1'b0, exp_wdata:32'h1111_1111, exp_rdata:32'hCAFE_F00D};
    vecs[3] = '{d:1'b0, we:1'b0, addr:32'h84,  wdata:32'hA5A5_A5A5, exp_we:1'b0, exp_wdata:32'h0,         exp_rdata:32'h5A5A_0084};
    vecs[4] = '{d:1'b1, we:1'b1, addr:32'h3C,  wdata:32'h1234_5678, exp_we:1'b1, exp_wdata:32'h1234_5678, exp_rdata:32'h0};
    vecs[5] = '{d:1'b1, we:1'b0, addr:32'h7C,  wdata:32'h0,         exp_we:1'b0, exp_wdata:32'h0,         exp_rdata:32'h5A5A_007C};

    repeat (3) tick();
    @(negedge clk);
    chk_all_zero("reset_outputs");
    tick();
    rst = 1'b0;

    for (int k = 0; k < 6; k++)
      run_vec(vecs[k], $sformatf("vec%0d", k));

    // Both requesters held high for 8 accesses.
    do_reset();
    for (int k = 0; k < 8; k++) begin
`ifdef ARB_DATA_PRIORITY_EN
      e = 1'b1;
`else
      e = (k % 2) == 1;
`endif
      gq.push_back(e);
      r.d = e;
      r.data = mem_val(e ? 32'h300 : 32'h80);
      rq.push_back(r);
    end
    i_addr = 32'h80;
    d_addr = 32'h300;
    d_we   = 1'b0;
    i_req  = 1'b1;
    d_req  = 1'b1;
    ng = 0;
    c  = 0;
    while (ng < 8 && c < 400) begin
      @(negedge clk);
      c++;
      if (i_gnt || d_gnt) ng++;
    end
    tick();
    i_req = 1'b0;
    d_req = 1'b0;
    chk("alt_gnt_count", ng, 8);
    c = 0;
    while (rq.size() > 0 && c < 100) begin
      tick();
      c++;
    end
    chk("alt_drain", rq.size(), 0);

    // Reset during WAIT of an I read aborts it silently.
    do_reset();
    run_vec(vecs[0], "pre_abort");
    gq.push_back(1'b0);
    i_addr = 32'h44;
    i_req  = 1'b1;
    wait_sig(1'b0, 1'b1, c);
    chk("abort_gnt_seen", c < 40, 1);
    tick();
    i_req = 1'b0;
    rst   = 1'b1;
    tick();
    @(negedge clk);
    chk_all_zero("abort_outputs");
    tick();
    rst = 1'b0;
    last_i = '0;
    cnt = 0;
    for (int k = 0; k < LAT + 4; k++) begin
      @(negedge clk);
      if (i_rvalid) cnt++;
    end
    chk("abort_no_rvalid", cnt, 0);
    tick();
    v = '{d:1'b0, we:1'b0, addr:32'h48, wdata:32'h0, exp_we:1'b0, exp_wdata:32'h0, exp_rdata:32'h5A5A_0048};
    run_vec(v, "post_abort");

    // D request arriving while an I read is waiting.
    gq.push_back(1'b0);
    gq.push_back(1'b1);
    r.d = 1'b0; r.data = mem_val(32'h50);  rq.push_back(r);
    r.d = 1'b1; r.data = mem_val(32'h204); rq.push_back(r);
    i_addr = 32'h50;
    i_req  = 1'b1;
    wait_sig(1'b0, 1'b1, c);
    chk("late_d_i_gnt_seen", c < 40, 1);
    tick();
    i_req  = 1'b0;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h204;
    c  = 0;
    ri = -100;
    dg = -1;
    while (c < 40 && dg < 0) begin
      @(negedge clk);
      c++;
      if (i_rvalid) ri = c;
      if (d_gnt) dg = c;
    end
    chk("late_d_i_latency", ri, LAT + 1);
    chk("late_d_gap", dg - ri, 2);
    tick();
    d_req = 1'b0;
    wait_sig(1'b1, 1'b0, c);
    chk("late_d_latency", c, LAT + 1);
    chk("late_d_i_rdata_held", i_rdata, mem_val(32'h50));
    repeat (2) tick();

    chk("scoreboard_empty", {gq.size(), rq.size()}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
